// File: rtl/hist_tx_pkg.sv
// Shared types and constants for the history-FSM pattern transmitter.
// Holds the transmitter state encoding, the idle line level and the length-width helper.
package hist_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b0;

  // Bits needed to express a pattern length from 0 up to and including width.
  function automatic int calc_len_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hist_bit_timer.sv
// Bit-period timer: strobes bit_end on the last clock of every DIV-clock bit period.
// The count restarts from zero whenever start is asserted.
module hist_bit_timer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = enable && (cnt_q == LAST);

endmodule

// File: rtl/hist_pattern_tx.sv
// Serial stimulus transmitter for the history FSM: shifts a loaded pattern out LSB-first on `a`
// and captures the FSM x/y feedback per bit. Define HIST_PATTERN_TX_PARITY_EN to append an even-parity bit.
module hist_pattern_tx
  import hist_tx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV   = 1,
  parameter int LEN_W = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             a,
  input  logic             x_in,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resp_x,
  output logic [WIDTH-1:0] resp_y
);

  localparam logic [WIDTH-1:0] FIRST_MASK = WIDTH'(1);
  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(WIDTH);

  tx_state_e        state_q, state_d;
  logic             a_q, a_d;
  logic             load_ready_q, load_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] resp_x_q, resp_x_d;
  logic [WIDTH-1:0] resp_y_q, resp_y_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [LEN_W-1:0] left_q, left_d;

  logic             accept;
  logic [LEN_W-1:0] len_clamped;
  logic             bit_end;

`ifdef HIST_PATTERN_TX_PARITY_EN
  logic             par_q, par_d;
  logic             par_phase_q, par_phase_d;
  logic [WIDTH-1:0] len_mask;

  always_comb begin
    len_mask = '0;
    for (int k = 0; k < WIDTH; k++) begin
      len_mask[k] = (k < int'(len_clamped));
    end
  end
`endif

  assign accept      = load_valid && load_ready_q;
  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  hist_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .enable (state_q == SHIFT),
    .bit_end(bit_end)
  );

  // data_q holds only the bits not yet placed on `a`; mask_q marks the response slot of the current bit.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    load_ready_d = load_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resp_x_d     = resp_x_q;
    resp_y_d     = resp_y_q;
    data_d       = data_q;
    mask_d       = mask_q;
    left_d       = left_q;
`ifdef HIST_PATTERN_TX_PARITY_EN
    par_d        = par_q;
    par_phase_d  = par_phase_q;
`endif

    case (state_q)
      IDLE: begin
        a_d          = IDLE_LEVEL;
        load_ready_d = 1'b1;
        busy_d       = 1'b0;
        if (accept) begin
          data_d       = load_data >> 1;
          mask_d       = FIRST_MASK;
          left_d       = len_clamped;
          resp_x_d     = '0;
          resp_y_d     = '0;
          load_ready_d = 1'b0;
`ifdef HIST_PATTERN_TX_PARITY_EN
          par_d       = ^(load_data & len_mask);
          par_phase_d = (len_clamped == '0);
          state_d     = SHIFT;
          busy_d      = 1'b1;
          a_d         = (len_clamped == '0) ? IDLE_LEVEL : load_data[0];
`else
          if (len_clamped != '0) begin
            state_d = SHIFT;
            busy_d  = 1'b1;
            a_d     = load_data[0];
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end

      SHIFT: begin
`ifdef HIST_PATTERN_TX_PARITY_EN
        if (bit_end && par_phase_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = IDLE_LEVEL;
        end else if (bit_end) begin
          resp_x_d = resp_x_q | (x_in ? mask_q : '0);
          resp_y_d = resp_y_q | (y_in ? mask_q : '0);
          data_d   = data_q >> 1;
          mask_d   = mask_q << 1;
          left_d   = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) begin
            par_phase_d = 1'b1;
            a_d         = par_q;
          end else begin
            a_d = data_q[0];
          end
        end
`else
        if (bit_end) begin
          resp_x_d = resp_x_q | (x_in ? mask_q : '0);
          resp_y_d = resp_y_q | (y_in ? mask_q : '0);
          data_d   = data_q >> 1;
          mask_d   = mask_q << 1;
          left_d   = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            a_d     = IDLE_LEVEL;
          end else begin
            a_d = data_q[0];
          end
        end
`endif
      end

      DONE: begin
        state_d      = IDLE;
        load_ready_d = 1'b1;
        busy_d       = 1'b0;
        a_d          = IDLE_LEVEL;
      end

      default: begin
        state_d      = IDLE;
        load_ready_d = 1'b1;
        busy_d       = 1'b0;
        a_d          = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= IDLE_LEVEL;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_x_q     <= '0;
      resp_y_q     <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      left_q       <= '0;
`ifdef HIST_PATTERN_TX_PARITY_EN
      par_q        <= 1'b0;
      par_phase_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_x_q     <= resp_x_d;
      resp_y_q     <= resp_y_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      left_q       <= left_d;
`ifdef HIST_PATTERN_TX_PARITY_EN
      par_q        <= par_d;
      par_phase_q  <= par_phase_d;
`endif
    end
  end

  assign a          = a_q;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign resp_x     = resp_x_q;
  assign resp_y     = resp_y_q;

endmodule
